elevator_sched: RTL and testbench

- Parametrised next-generation elevator controller for N floors, replacing the fixed 10-floor controller plus separate display decoder.
- Latches cabin and hall requests and serves them with direction-aware SCAN scheduling.
- Models travel time per floor and door dwell time with counters.
- Drives two 7-segment digits for the current floor directly; sits at the top level between button inputs and motor/door/display outputs.

---
 rtl/elevator_sched.sv | 215 +++++++++++++++++++++
 tb/tb_elevator_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_sched.sv
// elevator_sched: N-floor elevator controller with direction-aware SCAN
// scheduling, per-floor travel timing, door dwell timing and a direct
// two-digit 7-segment floor display.
// Optional feature: define DOOR_HOLD_EN to let door_hold keep the door open.
module elevator_sched #(
    parameter int FLOORS      = 10,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [FLOORS-1:0]         buttons,
    input  logic [FLOORS-1:0]         ups,
    input  logic [FLOORS-1:0]         downs,
    input  logic                      door_hold,
    output logic                      up,
    output logic                      down,
    output logic                      open,
    output logic [$clog2(FLOORS)-1:0] floor,
    output logic [FLOORS-1:0]         pending,
    output logic [6:0]                seg_tens,
    output logic [6:0]                seg_ones
);
    localparam int FW = $clog2(FLOORS);
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [FLOORS-1:0] TOP_BIT    = FLOORS'(1) << (FLOORS - 1);
    localparam logic [FLOORS-1:0] BOTTOM_BIT = FLOORS'(1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t            state, state_nx;
    logic              dir, dir_nx;
    logic [FW-1:0]     floor_nx;
    logic [MW-1:0]     mcnt, mcnt_nx;
    logic [DW-1:0]     dcnt, dcnt_nx;
    logic [FLOORS-1:0] car_req, up_req, down_req;
    logic [FLOORS-1:0] car_nx, up_nx, down_nx;
    logic [FLOORS-1:0] new_car, new_up, new_down;
    logic [FLOORS-1:0] here_mask, next_mask;
    logic              door_hit;
    logic              hold;

`ifdef DOOR_HOLD_EN
    assign hold = door_hold;
`else
    logic unused_door_hold;
    assign hold             = 1'b0;
    assign unused_door_hold = door_hold;
`endif

    assign pending = car_req | up_req | down_req;

    function automatic logic any_above(input logic [FLOORS-1:0] req, input int f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i > f && req[i]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] req, input int f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i < f && req[i]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [FLOORS-1:0] onehot(input int f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++)
            m[i] = (i == f);
        return m;
    endfunction

    function automatic logic [6:0] seg_digit(input int d);
        case (d)
            0:       seg_digit = 7'h3F;
            1:       seg_digit = 7'h06;
            2:       seg_digit = 7'h5B;
            3:       seg_digit = 7'h4F;
            4:       seg_digit = 7'h66;
            5:       seg_digit = 7'h6D;
            6:       seg_digit = 7'h7D;
            7:       seg_digit = 7'h07;
            8:       seg_digit = 7'h7F;
            9:       seg_digit = 7'h6F;
            default: seg_digit = 7'h00;
        endcase
    endfunction

    // Next-state logic: request latching, SCAN decisions, travel and door timers.
    always_comb begin
        state_nx  = state;
        dir_nx    = dir;
        floor_nx  = floor;
        mcnt_nx   = mcnt;
        dcnt_nx   = dcnt;
        here_mask = onehot(int'(floor));
        next_mask = '0;
        new_car   = buttons;
        new_up    = ups & ~TOP_BIT;
        new_down  = downs & ~BOTTOM_BIT;
        door_hit  = 1'b0;
        if (state == DOOR_OPEN) begin
            door_hit = |((new_car | new_up | new_down) & here_mask);
            new_car  = new_car & ~here_mask;
            new_up   = new_up & ~here_mask;
            new_down = new_down & ~here_mask;
        end
        car_nx  = car_req | new_car;
        up_nx   = up_req | new_up;
        down_nx = down_req | new_down;

        case (state)
            IDLE: begin
                if (|(pending & here_mask)) begin
                    state_nx = DOOR_OPEN;
                    car_nx   = car_nx & ~here_mask;
                    up_nx    = up_nx & ~here_mask;
                    down_nx  = down_nx & ~here_mask;
                end else if (any_above(pending, int'(floor)) &&
                             (dir || !any_below(pending, int'(floor)))) begin
                    state_nx = MOVE_UP;
                    dir_nx   = 1'b1;
                end else if (any_below(pending, int'(floor))) begin
                    state_nx = MOVE_DOWN;
                    dir_nx   = 1'b0;
                end
            end
            MOVE_UP: begin
                if (mcnt == MW'(MOVE_CYCLES - 1)) begin
                    mcnt_nx   = '0;
                    floor_nx  = floor + FW'(1);
                    next_mask = onehot(int'(floor) + 1);
                    if (|((car_req | up_req) & next_mask) ||
                        (|(down_req & next_mask) && !any_above(pending, int'(floor) + 1))) begin
                        state_nx = DOOR_OPEN;
                        car_nx   = car_nx & ~next_mask;
                        up_nx    = up_nx & ~next_mask;
                        if (!any_above(pending, int'(floor) + 1))
                            down_nx = down_nx & ~next_mask;
                    end
                end else begin
                    mcnt_nx = mcnt + MW'(1);
                end
            end
            MOVE_DOWN: begin
                if (mcnt == MW'(MOVE_CYCLES - 1)) begin
                    mcnt_nx   = '0;
                    floor_nx  = floor - FW'(1);
                    next_mask = onehot(int'(floor) - 1);
                    if (|((car_req | down_req) & next_mask) ||
                        (|(up_req & next_mask) && !any_below(pending, int'(floor) - 1))) begin
                        state_nx = DOOR_OPEN;
                        car_nx   = car_nx & ~next_mask;
                        down_nx  = down_nx & ~next_mask;
                        if (!any_below(pending, int'(floor) - 1))
                            up_nx = up_nx & ~next_mask;
                    end
                end else begin
                    mcnt_nx = mcnt + MW'(1);
                end
            end
            DOOR_OPEN: begin
                if (door_hit || hold) begin
                    dcnt_nx = '0;
                end else if (dcnt == DW'(DOOR_CYCLES - 1)) begin
                    dcnt_nx  = '0;
                    state_nx = IDLE;
                end else begin
                    dcnt_nx = dcnt + DW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, request and counter registers; motion outputs lag the state by one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dir      <= 1'b1;
            floor    <= '0;
            mcnt     <= '0;
            dcnt     <= '0;
            car_req  <= '0;
            up_req   <= '0;
            down_req <= '0;
            up       <= 1'b0;
            down     <= 1'b0;
            open     <= 1'b0;
        end else begin
            state    <= state_nx;
            dir      <= dir_nx;
            floor    <= floor_nx;
            mcnt     <= mcnt_nx;
            dcnt     <= dcnt_nx;
            car_req  <= car_nx;
            up_req   <= up_nx;
            down_req <= down_nx;
            up       <= (state == MOVE_UP);
            down     <= (state == MOVE_DOWN);
            open     <= (state == DOOR_OPEN);
        end
    end

    // Decimal display of the current floor; tens digit blanked below 10.
    always_comb begin
        seg_ones = seg_digit(int'(floor) % 10);
        seg_tens = (int'(floor) < 10) ? 7'h00 : seg_digit(int'(floor) / 10);
    end
endmodule

// File: tb/tb_elevator_sched.sv
// tb_elevator_sched: table-driven, directed and randomized checks of
// elevator_sched (16 floors) against a floor-by-floor behavioural model.
`timescale 1ns/1ps
module tb_elevator_sched;
    localparam int F  = 16;
    localparam int MC = 4;
    localparam int DC = 8;
    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;
`ifdef DOOR_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [F-1:0] buttons = '0, ups = '0, downs = '0;
    logic         door_hold = 1'b0;
    logic         up, down, open;
    logic [3:0]   floor;
    logic [F-1:0] pending;
    logic [6:0]   seg_tens, seg_ones;

    int checks = 0;
    int fails  = 0;

    logic [6:0] segTable [10];

    // behavioural model state
    int     mMode, mFloor, mTravel, mDoor;
    bit     mDirUp;
    bit [F-1:0] mCar, mUp, mDn;
    bit     eUp, eDown, eOpen;

    typedef struct {
        logic [F-1:0] b;
        logic [F-1:0] u;
        logic [F-1:0] d;
        int           waitN;
        int           expFloor;
        logic [2:0]   expMotion;
        logic [F-1:0] expPending;
        logic [13:0]  expSeg;
    } vec_t;
    vec_t vecs [10];

    elevator_sched #(.FLOORS(F), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
        .clock(clock), .reset(reset), .buttons(buttons), .ups(ups), .downs(downs),
        .door_hold(door_hold), .up(up), .down(down), .open(open), .floor(floor),
        .pending(pending), .seg_tens(seg_tens), .seg_ones(seg_ones)
    );

    always #5 clock = ~clock;

    function automatic logic [F-1:0] bitF(input int i);
        logic [F-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit anyIn(input bit [F-1:0] r, input int lo, input int hi);
        bit hit;
        hit = 1'b0;
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i < F && r[i]) hit = 1'b1;
        return hit;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mMode = M_IDLE; mFloor = 0; mTravel = 0; mDoor = 0; mDirUp = 1'b1;
        mCar = '0; mUp = '0; mDn = '0;
        eUp = 1'b0; eDown = 1'b0; eOpen = 1'b0;
    endtask

    // One clock edge of the reference elevator, using the values seen before the edge.
    task automatic modelStep(input logic [F-1:0] b, input logic [F-1:0] u,
                             input logic [F-1:0] d, input logic h);
        bit [F-1:0] nc, nu, nd, oc, ou, od, allq;
        bit restart;
        nc = b; nu = u; nd = d;
        nu[F-1] = 1'b0;
        nd[0]   = 1'b0;
        restart = 1'b0;
        if (mMode == M_DOOR && (nc[mFloor] || nu[mFloor] || nd[mFloor])) begin
            restart = 1'b1;
            nc[mFloor] = 1'b0; nu[mFloor] = 1'b0; nd[mFloor] = 1'b0;
        end
        oc = mCar; ou = mUp; od = mDn;
        allq = oc | ou | od;
        eUp   = (mMode == M_UP);
        eDown = (mMode == M_DOWN);
        eOpen = (mMode == M_DOOR);
        mCar = oc | nc; mUp = ou | nu; mDn = od | nd;
        case (mMode)
            M_IDLE: begin
                if (allq[mFloor]) begin
                    mMode = M_DOOR; mDoor = DC;
                    mCar[mFloor] = 1'b0; mUp[mFloor] = 1'b0; mDn[mFloor] = 1'b0;
                end else if (anyIn(allq, mFloor + 1, F - 1) &&
                             (mDirUp || !anyIn(allq, 0, mFloor - 1))) begin
                    mMode = M_UP; mDirUp = 1'b1; mTravel = MC;
                end else if (anyIn(allq, 0, mFloor - 1)) begin
                    mMode = M_DOWN; mDirUp = 1'b0; mTravel = MC;
                end
            end
            M_UP: begin
                mTravel--;
                if (mTravel == 0) begin
                    mFloor++;
                    mTravel = MC;
                    if (oc[mFloor] || ou[mFloor] || (od[mFloor] && !anyIn(allq, mFloor + 1, F - 1))) begin
                        mMode = M_DOOR; mDoor = DC;
                        mCar[mFloor] = 1'b0; mUp[mFloor] = 1'b0;
                        if (!anyIn(allq, mFloor + 1, F - 1)) mDn[mFloor] = 1'b0;
                    end
                end
            end
            M_DOWN: begin
                mTravel--;
                if (mTravel == 0) begin
                    mFloor--;
                    mTravel = MC;
                    if (oc[mFloor] || od[mFloor] || (ou[mFloor] && !anyIn(allq, 0, mFloor - 1))) begin
                        mMode = M_DOOR; mDoor = DC;
                        mCar[mFloor] = 1'b0; mDn[mFloor] = 1'b0;
                        if (!anyIn(allq, 0, mFloor - 1)) mUp[mFloor] = 1'b0;
                    end
                end
            end
            default: begin
                if (restart || (h && HOLD_ON)) begin
                    mDoor = DC;
                end else begin
                    mDoor--;
                    if (mDoor == 0) mMode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic checkModel();
        logic [13:0] expSeg;
        expSeg = {(mFloor < 10) ? 7'h00 : segTable[mFloor / 10], segTable[mFloor % 10]};
        checkOutput("motion", {29'd0, up, down, open}, {29'd0, eUp, eDown, eOpen});
        checkOutput("floor", 32'(floor), 32'(mFloor));
        checkOutput("pending", 32'(pending), 32'(mCar | mUp | mDn));
        checkOutput("display", {18'd0, seg_tens, seg_ones}, {18'd0, expSeg});
    endtask

    task automatic checkReset();
        checkOutput("reset_up", 32'(up), 32'd0);
        checkOutput("reset_down", 32'(down), 32'd0);
        checkOutput("reset_open", 32'(open), 32'd0);
        checkOutput("reset_floor", 32'(floor), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);
        checkOutput("reset_seg_ones", 32'(seg_ones), 32'h3F);
        checkOutput("reset_seg_tens", 32'(seg_tens), 32'h00);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge.
    task automatic doReset();
        @(negedge clock);
        #2 reset = 1'b0;
        #1 checkReset();
        modelReset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic applyStimulus(input logic [F-1:0] b, input logic [F-1:0] u,
                                 input logic [F-1:0] d, input logic h);
        buttons = b; ups = u; downs = d; door_hold = h;
        @(posedge clock);
        modelStep(b, u, d, h);
        #1;
        buttons = '0; ups = '0; downs = '0; door_hold = 1'b0;
        @(negedge clock);
        checkModel();
    endtask

    initial begin
        logic [F-1:0] rb, ru, rd;
        logic rh;
        int cnt, cntUp, guard, nOpen, open1, open2;
        logic prevOpen;

        segTable = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        vecs[0] = '{16'h0008, 16'h0000, 16'h0000, 14,  3, 3'b001, 16'h0000, {7'h00, 7'h4F}};
        vecs[1] = '{16'h0008, 16'h0000, 16'h0000,  8,  1, 3'b100, 16'h0008, {7'h00, 7'h06}};
        vecs[2] = '{16'h1000, 16'h0000, 16'h0000, 50, 12, 3'b001, 16'h0000, {7'h06, 7'h5B}};
        vecs[3] = '{16'h0000, 16'h8000, 16'h0000,  2,  0, 3'b000, 16'h0000, {7'h00, 7'h3F}};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0001,  2,  0, 3'b000, 16'h0000, {7'h00, 7'h3F}};
        vecs[5] = '{16'h0000, 16'h0001, 16'h0000,  2,  0, 3'b001, 16'h0000, {7'h00, 7'h3F}};
        vecs[6] = '{16'h0000, 16'h0000, 16'h0020,  1,  0, 3'b000, 16'h0020, {7'h00, 7'h3F}};
        vecs[7] = '{16'h0088, 16'h0000, 16'h0000, 14,  3, 3'b001, 16'h0080, {7'h00, 7'h4F}};
        vecs[8] = '{16'h0200, 16'h0000, 16'h0000, 37,  9, 3'b100, 16'h0000, {7'h00, 7'h6F}};
        vecs[9] = '{16'h0400, 16'h0000, 16'h0000, 42, 10, 3'b001, 16'h0000, {7'h06, 7'h3F}};

        modelReset();
        #1 reset = 1'b0;
        #2 checkReset();
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] table-driven vectors");
        for (int r = 0; r < 10; r++) begin
            doReset();
            applyStimulus(vecs[r].b, vecs[r].u, vecs[r].d, 1'b0);
            repeat (vecs[r].waitN) applyStimulus('0, '0, '0, 1'b0);
            checkOutput($sformatf("vec%0d_floor", r), 32'(floor), 32'(vecs[r].expFloor));
            checkOutput($sformatf("vec%0d_motion", r), {29'd0, up, down, open}, {29'd0, vecs[r].expMotion});
            checkOutput($sformatf("vec%0d_pending", r), 32'(pending), 32'(vecs[r].expPending));
            checkOutput($sformatf("vec%0d_display", r), {18'd0, seg_tens, seg_ones}, {18'd0, vecs[r].expSeg});
        end

        $display("[TB] single call to floor 3");
        doReset();
        applyStimulus(bitF(3), '0, '0, 1'b0);
        cnt = 0; cntUp = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus('0, '0, '0, 1'b0);
            if (up) cntUp++;
            if (open) cnt++;
        end
        checkOutput("single_up_cycles", 32'(cntUp), 32'd12);
        checkOutput("single_open_cycles", 32'(cnt), 32'd8);
        checkOutput("single_floor", 32'(floor), 32'd3);

        $display("[TB] SCAN ordering");
        doReset();
        applyStimulus(bitF(5), '0, '0, 1'b0);
        guard = 0;
        while (floor != 4'd1 && guard < 50) begin
            applyStimulus('0, '0, '0, 1'b0);
            guard++;
        end
        checkOutput("scan_reach1", 32'(floor), 32'd1);
        applyStimulus('0, '0, bitF(2), 1'b0);
        nOpen = 0; open1 = -1; open2 = -1; prevOpen = open;
        for (int c = 0; c < 100; c++) begin
            applyStimulus('0, '0, '0, 1'b0);
            if (open && !prevOpen) begin
                if (nOpen == 0) open1 = 32'(floor);
                else if (nOpen == 1) open2 = 32'(floor);
                nOpen++;
            end
            prevOpen = open;
        end
        checkOutput("scan_open_count", 32'(nOpen), 32'd2);
        checkOutput("scan_first_stop", 32'(open1), 32'd5);
        checkOutput("scan_second_stop", 32'(open2), 32'd2);

        $display("[TB] same-floor request");
        doReset();
        applyStimulus(bitF(4), '0, '0, 1'b0);
        guard = 0;
        while (!open && guard < 100) begin applyStimulus('0, '0, '0, 1'b0); guard++; end
        while (open && guard < 100) begin applyStimulus('0, '0, '0, 1'b0); guard++; end
        checkOutput("same_wait_bound", 32'(guard < 100), 32'd1);
        checkOutput("same_at4", 32'(floor), 32'd4);
        applyStimulus('0, bitF(4), '0, 1'b0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("same_open_k1", 32'(open), 32'd0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("same_open_k2", 32'(open), 32'd1);
        applyStimulus('0, '0, '0, 1'b0);
        applyStimulus('0, bitF(4), '0, 1'b0);
        checkOutput("same_pending", 32'(pending), 32'd0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus('0, '0, '0, 1'b0);
            if (open) cnt++;
        end
        checkOutput("same_extend", 32'(cnt), 32'd8);

        $display("[TB] door hold");
        doReset();
        applyStimulus('0, bitF(0), '0, 1'b0);
        applyStimulus('0, '0, '0, 1'b0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus('0, '0, '0, 1'b1);
            if (open) cnt++;
        end
        for (int c = 0; c < 40; c++) begin
            applyStimulus('0, '0, '0, 1'b0);
            if (open) cnt++;
        end
        checkOutput("door_hold_len", 32'(cnt), HOLD_ON ? 32'd28 : 32'd8);

        $display("[TB] randomized traffic");
        doReset();
        for (int c = 0; c < 3000; c++) begin
            rb = '0; ru = '0; rd = '0;
            if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, F - 1)] = 1'b1;
            if ($urandom_range(0, 9) == 0) ru[$urandom_range(0, F - 1)] = 1'b1;
            if ($urandom_range(0, 9) == 0) rd[$urandom_range(0, F - 1)] = 1'b1;
            rh = ($urandom_range(0, 3) == 0);
            if (c == 1500) doReset();
            applyStimulus(rb, ru, rd, rh);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
